dpram_be: RTL and testbench
===========================

DPRAM_BE -- requirements
Module: dpram_be

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits; must be a multiple of BYTE_WIDTH.
REQ-002 SHALL have parameter BYTE_WIDTH, default 8, bits per write-enable lane; NB = DATA_WIDTH/BYTE_WIDTH.
REQ-003 SHALL have parameter ADDR_WIDTH, default 10, address width.
REQ-004 SHALL have parameter RAM_DEPTH, default 1024, number of words; RAM_DEPTH <= 2^ADDR_WIDTH.
REQ-005 SHALL have parameter RD_LATENCY, default 1, read latency in cycles, legal range 1..4.
REQ-006 SHALL have parameter RDW_MODE, default 0, same-address read-during-write result: 0 old data, 1 new data.
REQ-007 SHALL have parameter CLEAR_ON_RESET, default 1, zero-fill the memory after reset when 1.
REQ-008 SHALL have port i_clk  input  1  single clock; all logic on its rising edge.
REQ-009 SHALL have port i_rst_n  input  1  reset; asynchronous assert, active-low.
REQ-010 SHALL have port i_we_a  input  1  port A write request.
REQ-011 SHALL have port i_be_a  input  NB  port A byte-lane enables.
REQ-012 SHALL have port i_addr_a  input  ADDR_WIDTH  port A write address.
REQ-013 SHALL have port i_data_a  input  DATA_WIDTH  port A write data.
REQ-014 SHALL have port i_en_b  input  1  port B read request.
REQ-015 SHALL have port i_addr_b  input  ADDR_WIDTH  port B read address.
REQ-016 SHALL have port o_data_b  output  DATA_WIDTH  read data.
REQ-017 SHALL have port o_valid_b  output  1  one-cycle pulse qualifying o_data_b.
REQ-018 SHALL have port o_init_done  output  1  high once the memory is usable.

Function
REQ-019 SHALL implement FSM states CLEAR and READY; after reset release enter CLEAR if CLEAR_ON_RESET=1, otherwise READY.
REQ-020 In CLEAR it SHALL write zero to address counter value, increment by 1 each cycle, and transition to READY after writing address RAM_DEPTH-1 (RAM_DEPTH cycles total).
REQ-021 o_init_done SHALL be 1 exactly when state is READY, registered; it never falls except on reset.
REQ-022 While not READY, i_we_a and i_en_b SHALL be ignored: no write, no read, no o_valid_b.
REQ-023 A write SHALL update only bytes whose i_be_a bit is 1; i_we_a=1 with i_be_a=0 changes nothing.
REQ-024 A read accepted at edge N (i_en_b=1, READY) SHALL present data with o_valid_b=1 at edge N+RD_LATENCY; back-to-back reads give back-to-back valid pulses, in order.
REQ-025 o_data_b SHALL hold its last value while o_valid_b=0; pipeline stages update only when their stage-valid is set.
REQ-026 Same-address read and write in one cycle: RDW_MODE=0 SHALL return pre-write word; RDW_MODE=1 SHALL return enabled bytes from i_data_a merged with remaining stored bytes.
REQ-027 Writes with i_addr_a >= RAM_DEPTH SHALL be dropped; reads with i_addr_b >= RAM_DEPTH SHALL return zero with normal o_valid_b timing.
REQ-028 Read to an address written one or more cycles earlier SHALL return the written data regardless of RDW_MODE.

Reset
REQ-029 i_rst_n=0 SHALL asynchronously force o_data_b=0, o_valid_b=0, o_init_done=0, all stage-valids 0, clear counter 0.
REQ-030 Memory array contents SHALL NOT be reset directly; zeroing is done only by the CLEAR sweep.
REQ-031 Reset asserted mid-CLEAR or mid-read SHALL discard in-flight reads and restart CLEAR from address 0 after release.

Structure
REQ-032 Package dpram_pkg SHALL hold RDW_OLD/RDW_NEW constants, MAX_RD_LATENCY=4, and the FSM state encoding.
REQ-033 Sub-module dpram_rd_pipe SHALL implement the valid/data latency pipeline (RD_LATENCY stages) and be instanced once.
REQ-034 Elaboration SHALL fail on RD_LATENCY outside 1..4 or DATA_WIDTH not a multiple of BYTE_WIDTH.

Verification
REQ-035 Defaults, reset release: o_init_done rises after 1024 clear cycles; read of address 5 returns 0x00000000, o_valid_b 1 cycle after i_en_b.
REQ-036 Write 0xAABBCCDD to addr 3 be=4'b1111, then be=4'b0101 data 0x11223344: read returns 0xAA22CC44.
REQ-037 RD_LATENCY=3, reads to addrs 0,1,2 on consecutive cycles: three valid pulses on cycles +3,+4,+5 in order; o_data_b holds afterwards.
REQ-038 Addr 7 holds 0x0; same cycle write 0xDEADBEEF be=1111 and read addr 7: RDW_MODE=0 returns 0x0, RDW_MODE=1 returns 0xDEADBEEF.
REQ-039 Reset pulsed at clear cycle 500: outputs zero immediately; o_init_done rises 1024 cycles after release; reads/writes during CLEAR produce no valid and no change.
REQ-040 RAM_DEPTH=1000: write to addr 1010 dropped; read of addr 1010 returns 0 with valid; addr 999 writes/reads correctly.

Source files
------------

// File: rtl/dpram_pkg.sv
// dpram_pkg: shared constants and FSM state encoding for the dpram_be block.
//   RDW_OLD / RDW_NEW : values of RDW_MODE (old word / merged new word)
//   MAX_RD_LATENCY    : deepest read pipeline supported
//   dpram_state_e     : CLEAR (zero-fill sweep) / READY (normal operation)
package dpram_pkg;
    localparam int RDW_OLD        = 0;
    localparam int RDW_NEW        = 1;
    localparam int MAX_RD_LATENCY = 4;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } dpram_state_e;
endpackage

// File: rtl/dpram_be_if.sv
// dpram_be_if: bus bundle between a user (master) and the dpram_be RAM (slave).
//   Write port A : i_we_a, i_be_a[NB], i_addr_a, i_data_a
//   Read port B  : i_en_b, i_addr_b  ->  o_data_b, o_valid_b
//   Status       : o_init_done (memory usable)
interface dpram_be_if #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
);
    localparam int NB = DATA_WIDTH / BYTE_WIDTH;

    logic                  i_we_a;
    logic [NB-1:0]         i_be_a;
    logic [ADDR_WIDTH-1:0] i_addr_a;
    logic [DATA_WIDTH-1:0] i_data_a;
    logic                  i_en_b;
    logic [ADDR_WIDTH-1:0] i_addr_b;
    logic [DATA_WIDTH-1:0] o_data_b;
    logic                  o_valid_b;
    logic                  o_init_done;

    modport master (
        output i_we_a, i_be_a, i_addr_a, i_data_a, i_en_b, i_addr_b,
        input  o_data_b, o_valid_b, o_init_done
    );
    modport slave (
        input  i_we_a, i_be_a, i_addr_a, i_data_a, i_en_b, i_addr_b,
        output o_data_b, o_valid_b, o_init_done
    );
endinterface

// File: rtl/dpram_rd_pipe.sv
// dpram_rd_pipe: read-data latency pipeline, STAGES registers deep.
//   i_vld/i_data : read accepted this cycle and its (already resolved) word
//   o_vld/o_data : word STAGES cycles later; o_data holds between pulses
// Each data stage loads only when the stage feeding it is valid, so the
// output keeps the last delivered word while idle.
module dpram_rd_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_vld,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_vld,
    output logic [DATA_WIDTH-1:0] o_data
);
    logic [STAGES:1]                 vld_pipe;
    logic [STAGES:1][DATA_WIDTH-1:0] dat_pipe;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[1] <= i_vld;
            if (i_vld) dat_pipe[1] <= i_data;
            for (int s = 2; s <= STAGES; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
            end
        end
    end

    assign o_vld  = vld_pipe[STAGES];
    assign o_data = dat_pipe[STAGES];
endmodule

// File: rtl/dpram_be.sv
// dpram_be: simple dual-port RAM, byte-enable write port A, read port B.
//   i_clk, i_rst_n : single clock, async active-low reset
//   bus (slave)    : write/read ports, o_data_b/o_valid_b, o_init_done
// After reset an optional sweep zero-fills the array (CLEAR), then READY.
// Requests are ignored until o_init_done. Out-of-range writes are dropped,
// out-of-range reads return zero with normal timing.
module dpram_be
    import dpram_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 10,
    parameter int RAM_DEPTH      = 1024,
    parameter int RD_LATENCY     = 1,
    parameter int RDW_MODE       = RDW_OLD,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic   i_clk,
    input  logic   i_rst_n,
    dpram_be_if.slave bus
);
    localparam int NB = DATA_WIDTH / BYTE_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam dpram_state_e RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

    generate
        if (RD_LATENCY < 1 || RD_LATENCY > MAX_RD_LATENCY) begin : g_bad_lat
            $error("dpram_be: RD_LATENCY must be 1..4");
        end
        if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
            $error("dpram_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
        end
        if (RAM_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
            $error("dpram_be: RAM_DEPTH exceeds address space");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    dpram_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q;
    logic                  init_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: if (clr_cnt_q == LAST_ADDR) state_d = ST_READY;
            ST_READY: state_d = ST_READY;
            default:  state_d = RST_STATE;
        endcase
    end

    // init_q tracks the next state so it is high in exactly the READY cycles
    // and doubles as the request gate.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= RST_STATE;
            clr_cnt_q <= '0;
            init_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            init_q  <= (state_d == ST_READY);
            if (state_q == ST_CLEAR) clr_cnt_q <= clr_cnt_q + ADDR_WIDTH'(1);
        end
    end

    logic wr_hit, rd_acc, rd_in_rng;
    assign wr_hit    = init_q && bus.i_we_a && ({1'b0, bus.i_addr_a} < DEPTH_W);
    assign rd_acc    = init_q && bus.i_en_b;
    assign rd_in_rng = ({1'b0, bus.i_addr_b} < DEPTH_W);

    // Array itself is never reset; zeroing comes only from the sweep.
    always_ff @(posedge i_clk) begin
        if (state_q == ST_CLEAR) begin
            mem[clr_cnt_q] <= '0;
        end else if (wr_hit) begin
            for (int b = 0; b < NB; b++)
                if (bus.i_be_a[b])
                    mem[bus.i_addr_a][b*BYTE_WIDTH +: BYTE_WIDTH] <= bus.i_data_a[b*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    // Array read happens before this edge's write lands, so the plain read
    // is the old word; new-data mode patches in the enabled write bytes.
    logic [DATA_WIDTH-1:0] rd_data;
    always_comb begin
        rd_data = rd_in_rng ? mem[bus.i_addr_b] : '0;
        if (RDW_MODE == RDW_NEW && wr_hit && bus.i_addr_a == bus.i_addr_b) begin
            for (int b = 0; b < NB; b++)
                if (bus.i_be_a[b])
                    rd_data[b*BYTE_WIDTH +: BYTE_WIDTH] = bus.i_data_a[b*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    logic                  pipe_vld;
    logic [DATA_WIDTH-1:0] pipe_data;

    dpram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .STAGES     (RD_LATENCY)
    ) u_rd_pipe (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_vld   (rd_acc),
        .i_data  (rd_data),
        .o_vld   (pipe_vld),
        .o_data  (pipe_data)
    );

    assign bus.o_valid_b   = pipe_vld;
    assign bus.o_data_b    = pipe_data;
    assign bus.o_init_done = init_q;
endmodule

// File: tb/tb_dpram_be.sv
// tb_dpram_be: two instances driven by the same stimulus.
//   u0: defaults (latency 1, old-data RDW, depth 1024)
//   u1: latency 3, new-data RDW, depth 1000
// Expected reads go into per-instance queues {data, cycle}; a negedge
// monitor pops and compares them, and checks data hold while idle.
module tb_dpram_be;
    import dpram_pkg::*;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    logic        we, en;
    logic [3:0]  be;
    logic [9:0]  aa, ab;
    logic [31:0] da;

    dpram_be_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(10)) if0 ();
    dpram_be_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(10)) if1 ();

    assign if0.i_we_a = we;  assign if1.i_we_a = we;
    assign if0.i_be_a = be;  assign if1.i_be_a = be;
    assign if0.i_addr_a = aa; assign if1.i_addr_a = aa;
    assign if0.i_data_a = da; assign if1.i_data_a = da;
    assign if0.i_en_b = en;  assign if1.i_en_b = en;
    assign if0.i_addr_b = ab; assign if1.i_addr_b = ab;

    dpram_be u0 (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(if0));
    dpram_be #(.RD_LATENCY(3), .RDW_MODE(RDW_NEW), .RAM_DEPTH(1000)) u1
        (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(if1));

    typedef struct { logic [31:0] d; int c; } exp_t;
    typedef struct {
        logic we; logic [3:0] be; logic [9:0] aa; logic [31:0] da;
        logic en; logic [9:0] ab; logic [31:0] e0; logic [31:0] e1;
    } vec_t;

    exp_t q0[$], q1[$];
    logic [31:0] m0 [1024];
    logic [31:0] m1 [1024];
    logic [31:0] last [2];
    logic        pinit [2];
    int          rise [2];
    int          rel;
    int          nchk = 0, nfail = 0;
    vec_t        tbl [27];

    function automatic vec_t mk(logic w, logic [3:0] b, int a, logic [31:0] d,
                                logic e, int r, logic [31:0] x0, logic [31:0] x1);
        vec_t v;
        v.we = w; v.be = b; v.aa = 10'(a); v.da = d;
        v.en = e; v.ab = 10'(r); v.e0 = x0; v.e1 = x1;
        return v;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [3:0] b);
        logic [31:0] r = o;
        for (int i = 0; i < 4; i++) if (b[i]) r[i*8 +: 8] = n[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] pred(int id, vec_t v);
        int depth = (id == 1) ? 1000 : 1024;
        logic [31:0] r;
        if (int'(v.ab) >= depth) return 32'h0;
        r = (id == 1) ? m1[v.ab] : m0[v.ab];
        if (id == 1 && v.we && v.aa == v.ab) r = merge(r, v.da, v.be);
        return r;
    endfunction

    task automatic ck(string nm, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic zero_model();
        for (int i = 0; i < 1024; i++) begin m0[i] = '0; m1[i] = '0; end
    endtask

    task automatic apply(vec_t v, bit use_model);
        logic [31:0] x0 = v.e0, x1 = v.e1;
        we = v.we; be = v.be; aa = v.aa; da = v.da; en = v.en; ab = v.ab;
        if (v.en) begin
            if (use_model) begin x0 = pred(0, v); x1 = pred(1, v); end
            q0.push_back('{x0, cyc + 1});
            q1.push_back('{x1, cyc + 3});
        end
        if (v.we) begin
            m0[v.aa] = merge(m0[v.aa], v.da, v.be);
            if (int'(v.aa) < 1000) m1[v.aa] = merge(m1[v.aa], v.da, v.be);
        end
        @(posedge i_clk); #1;
        we = 0; en = 0;
    endtask

    task automatic chk(int id, logic v, logic [31:0] d, logic init);
        exp_t e;
        if (!i_rst_n) begin last[id] = '0; pinit[id] = 1'b0; return; end
        if (init && !pinit[id]) rise[id] = cyc;
        if (!init && pinit[id]) ck($sformatf("init_fall%0d", id), 32'(init), 32'h1);
        pinit[id] = init;
        if (v) begin
            if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
                ck($sformatf("unexpected_valid%0d@%0d", id, cyc), 32'(v), 32'h0);
            end else begin
                e = (id == 0) ? q0.pop_front() : q1.pop_front();
                ck($sformatf("rd_data%0d@%0d", id, cyc), d, e.d);
                ck($sformatf("rd_cycle%0d", id), 32'(cyc), 32'(e.c));
                last[id] = d;
            end
        end else begin
            ck($sformatf("hold%0d@%0d", id, cyc), d, last[id]);
        end
    endtask

    always @(negedge i_clk) begin
        chk(0, if0.o_valid_b, if0.o_data_b, if0.o_init_done);
        chk(1, if1.o_valid_b, if1.o_data_b, if1.o_init_done);
    end

    task automatic wait_init(string nm);
        for (int i = 0; i < 1100 && !(if0.o_init_done && if1.o_init_done); i++) begin
            @(posedge i_clk); #1;
        end
        @(negedge i_clk); #1;
        ck({nm, "_rise0"}, 32'(rise[0] - rel), 32'd1024);
        ck({nm, "_rise1"}, 32'(rise[1] - rel), 32'd1000);
    endtask

    task automatic check_reset_outs(string nm);
        ck({nm, "_data0"}, if0.o_data_b, 32'h0);
        ck({nm, "_data1"}, if1.o_data_b, 32'h0);
        ck({nm, "_valid0"}, 32'(if0.o_valid_b), 32'h0);
        ck({nm, "_valid1"}, 32'(if1.o_valid_b), 32'h0);
        ck({nm, "_init0"}, 32'(if0.o_init_done), 32'h0);
        ck({nm, "_init1"}, 32'(if1.o_init_done), 32'h0);
    endtask

    task automatic release_rst();
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        rel = cyc;
        rise[0] = -1; rise[1] = -1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        we = 0; be = 0; aa = 0; da = 0; en = 0; ab = 0;
        last[0] = 0; last[1] = 0; pinit[0] = 0; pinit[1] = 0;
        rise[0] = -1; rise[1] = -1; rel = 0;
        zero_model();

        tbl[0]  = mk(0, 4'h0, 0,    32'h0,        1, 5,    32'h0,        32'h0);
        tbl[1]  = mk(1, 4'hF, 3,    32'hAABBCCDD, 0, 0,    32'h0,        32'h0);
        tbl[2]  = mk(1, 4'h5, 3,    32'h11223344, 0, 0,    32'h0,        32'h0);
        tbl[3]  = mk(0, 4'h0, 0,    32'h0,        1, 3,    32'hAA22CC44, 32'hAA22CC44);
        tbl[4]  = mk(1, 4'h0, 9,    32'hFFFFFFFF, 0, 0,    32'h0,        32'h0);
        tbl[5]  = mk(0, 4'h0, 0,    32'h0,        1, 9,    32'h0,        32'h0);
        tbl[6]  = mk(1, 4'hF, 7,    32'hDEADBEEF, 1, 7,    32'h0,        32'hDEADBEEF);
        tbl[7]  = mk(0, 4'h0, 0,    32'h0,        1, 7,    32'hDEADBEEF, 32'hDEADBEEF);
        tbl[8]  = mk(1, 4'hF, 1010, 32'h12345678, 0, 0,    32'h0,        32'h0);
        tbl[9]  = mk(0, 4'h0, 0,    32'h0,        1, 1010, 32'h12345678, 32'h0);
        tbl[10] = mk(1, 4'hF, 999,  32'hCAFEF00D, 0, 0,    32'h0,        32'h0);
        tbl[11] = mk(0, 4'h0, 0,    32'h0,        1, 999,  32'hCAFEF00D, 32'hCAFEF00D);
        tbl[12] = mk(1, 4'hF, 0,    32'hA0A0A0A0, 0, 0,    32'h0,        32'h0);
        tbl[13] = mk(1, 4'hF, 1,    32'hA1A1A1A1, 0, 0,    32'h0,        32'h0);
        tbl[14] = mk(1, 4'hF, 2,    32'hA2A2A2A2, 0, 0,    32'h0,        32'h0);
        tbl[15] = mk(0, 4'h0, 0,    32'h0,        1, 0,    32'hA0A0A0A0, 32'hA0A0A0A0);
        tbl[16] = mk(0, 4'h0, 0,    32'h0,        1, 1,    32'hA1A1A1A1, 32'hA1A1A1A1);
        tbl[17] = mk(0, 4'h0, 0,    32'h0,        1, 2,    32'hA2A2A2A2, 32'hA2A2A2A2);
        tbl[18] = mk(0, 4'h0, 0,    32'h0,        0, 0,    32'h0,        32'h0);
        tbl[19] = mk(0, 4'h0, 0,    32'h0,        0, 0,    32'h0,        32'h0);
        tbl[20] = mk(0, 4'h0, 0,    32'h0,        0, 0,    32'h0,        32'h0);
        tbl[21] = mk(1, 4'h8, 3,    32'h55667788, 1, 3,    32'hAA22CC44, 32'h5522CC44);
        tbl[22] = mk(0, 4'h0, 0,    32'h0,        1, 3,    32'h5522CC44, 32'h5522CC44);
        tbl[23] = mk(1, 4'h2, 2,    32'h0000BB00, 1, 1,    32'hA1A1A1A1, 32'hA1A1A1A1);
        tbl[24] = mk(0, 4'h0, 0,    32'h0,        1, 2,    32'hA2A2BBA2, 32'hA2A2BBA2);
        tbl[25] = mk(0, 4'h0, 0,    32'h0,        1, 1023, 32'h0,        32'h0);
        tbl[26] = mk(0, 4'h0, 0,    32'h0,        0, 0,    32'h0,        32'h0);

        // reset state, then release and cut the sweep short at cycle 500
        repeat (3) @(posedge i_clk);
        #1 check_reset_outs("por");
        release_rst();
        while (cyc < rel + 500) begin @(posedge i_clk); #1; end
        #2 i_rst_n = 1'b0;
        q0.delete(); q1.delete(); zero_model();
        #1 check_reset_outs("clr_rst");

        // second sweep with traffic that must be ignored
        release_rst();
        for (int i = 0; i < 300; i++) begin
            we = 1'($urandom); en = 1'($urandom); be = 4'($urandom);
            aa = 10'($urandom_range(0, 15)); ab = 10'($urandom_range(0, 15));
            da = $urandom;
            @(posedge i_clk); #1;
        end
        we = 0; en = 0;
        wait_init("clear");

        for (int i = 0; i < 27; i++) apply(tbl[i], 1'b0);

        for (int i = 0; i < 60; i++) begin
            v.we = 1'($urandom); v.en = 1'($urandom); v.be = 4'($urandom);
            v.da = $urandom;
            v.aa = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(995, 1023)) : 10'($urandom_range(0, 15));
            v.ab = ($urandom_range(0, 2) == 0) ? v.aa :
                   (($urandom_range(0, 3) == 0) ? 10'($urandom_range(995, 1023)) : 10'($urandom_range(0, 15)));
            v.e0 = 0; v.e1 = 0;
            apply(v, 1'b1);
        end
        repeat (6) begin @(posedge i_clk); #1; end
        ck("drain0", 32'(q0.size()), 32'h0);
        ck("drain1", 32'(q1.size()), 32'h0);

        // reset with reads in flight: both are discarded
        apply(mk(0, 4'h0, 0, 32'h0, 1, 3, 32'h0, 32'h0), 1'b1);
        apply(mk(0, 4'h0, 0, 32'h0, 1, 1, 32'h0, 32'h0), 1'b1);
        #2 i_rst_n = 1'b0;
        q0.delete(); q1.delete(); zero_model();
        #1 check_reset_outs("rd_rst");
        release_rst();
        wait_init("rd_rst");
        apply(mk(0, 4'h0, 0, 32'h0, 1, 3, 32'h0, 32'h0), 1'b0);
        repeat (6) begin @(posedge i_clk); #1; end
        ck("final0", 32'(q0.size()), 32'h0);
        ck("final1", 32'(q1.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
